bl_wl_config_writer: RTL and testbench

// - Drives a memory-bank configuration array in a tile through bl/wl. It is the programming master for

---
 rtl/cfg_mem_bank_pkg.sv | 15 +
 rtl/bl_wl_config_writer_if.sv | 8 +
 rtl/bl_wl_config_writer_wl_onehot_decoder.sv | 15 +
 rtl/bl_wl_config_writer.sv | 100 ++++++++++
 tb/tb_bl_wl_config_writer.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cfg_mem_bank_pkg.sv
// cfg_mem_bank_pkg: shared FSM states and width helpers for the bl/wl config writer
package cfg_mem_bank_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, SETUP, PULSE, HOLD, DONE} state_t;
  // row index width, kept at least one bit so a single-row array still has a port
  function automatic int row_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  // phase counter width: must hold the largest (phase length - 1)
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return m > 2 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/bl_wl_config_writer_if.sv
// bl_wl_config_writer_if: valid/ready row-word stream from the bitstream loader
interface bl_wl_config_writer_if #(parameter int NUM_BL = 8);
  logic [NUM_BL-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, output valid, input ready);
  modport slave (input data, input valid, output ready);
endinterface

// File: rtl/bl_wl_config_writer_wl_onehot_decoder.sv
// wl_onehot_decoder: row index to one-hot word-line vector, all zero when disabled
module wl_onehot_decoder #(
  parameter int ROW_W = 3,
  parameter int NUM_WL = 8
) (
  input logic en,
  input logic [ROW_W-1:0] row,
  output logic [0:NUM_WL-1] wl
);
  // compare against every line index so out-of-range rows never select a line
  always_comb begin
    wl = '0;
    for (int i = 0; i < NUM_WL; i++) wl[i] = en && row == ROW_W'(i);
  end
endmodule

// File: rtl/bl_wl_config_writer.sv
// bl_wl_config_writer: sequences one row word per word line into a tile config array
module bl_wl_config_writer
  import cfg_mem_bank_pkg::*;
#(
  parameter int NUM_BL = 8,
  parameter int NUM_WL = 8,
  parameter int BL_SETUP_CYC = 1,
  parameter int WL_PULSE_CYC = 2,
  parameter int BL_HOLD_CYC = 1
) (
  input logic prog_clk,
  input logic pReset,
  input logic cfg_start,
  bl_wl_config_writer_if.slave cfg,
  output logic [0:NUM_BL-1] bl,
  output logic [0:NUM_WL-1] wl,
  output logic [row_w(NUM_WL)-1:0] cfg_row,
  output logic cfg_busy,
  output logic cfg_done
);
  localparam int RW = row_w(NUM_WL);
  localparam int CW = cnt_w(BL_SETUP_CYC, WL_PULSE_CYC, BL_HOLD_CYC);
  localparam logic [RW-1:0] LAST = RW'(NUM_WL - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] row_n;
  logic [0:NUM_BL-1] bl_n;
  logic [0:NUM_WL-1] wl_n;
  logic busy_n, done_n;
  // next state: one phase counter reloaded on every phase entry
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    row_n = cfg_row;
    bl_n = bl;
    busy_n = cfg_busy;
    done_n = cfg_done;
    case (state)
      IDLE, DONE: if (cfg_start) begin
        state_n = FETCH;
        row_n = '0;
        busy_n = 1'b1;
        done_n = 1'b0;
      end
      FETCH: if (cfg.valid && cfg.ready) begin
        state_n = SETUP;
        cnt_n = CW'(BL_SETUP_CYC - 1);
        for (int i = 0; i < NUM_BL; i++) bl_n[i] = cfg.data[i];
      end
      SETUP: if (cnt != '0) cnt_n = cnt - CW'(1);
      else begin
        state_n = PULSE;
        cnt_n = CW'(WL_PULSE_CYC - 1);
      end
      PULSE: if (cnt != '0) cnt_n = cnt - CW'(1);
      else begin
        state_n = HOLD;
        cnt_n = CW'(BL_HOLD_CYC - 1);
      end
      HOLD: if (cnt != '0) cnt_n = cnt - CW'(1);
      else if (cfg_row == LAST) begin
        state_n = DONE;
        busy_n = 1'b0;
        done_n = 1'b1;
        bl_n = '0;
      end else begin
        state_n = FETCH;
        row_n = cfg_row + RW'(1);
      end
      default: state_n = IDLE;
    endcase
  end
  wl_onehot_decoder #(.ROW_W(RW), .NUM_WL(NUM_WL)) u_dec (
    .en(state_n == PULSE),
    .row(row_n),
    .wl(wl_n)
  );
  // register state and every output; reset drops wl in the same edge
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state <= IDLE;
      cnt <= '0;
      cfg_row <= '0;
      bl <= '0;
      wl <= '0;
      cfg.ready <= 1'b0;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cfg_row <= row_n;
      bl <= bl_n;
      wl <= wl_n;
      cfg.ready <= state_n == FETCH;
      cfg_busy <= busy_n;
      cfg_done <= done_n;
    end
  end
endmodule

// File: tb/tb_bl_wl_config_writer.sv
// tb_bl_wl_config_writer: default and reduced-parameter writers against a phase-position model
module tb_bl_wl_config_writer;
  localparam int S[2] = '{1, 2};
  localparam int P[2] = '{2, 3};
  localparam int H[2] = '{1, 1};
  localparam int NW[2] = '{8, 4};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic valid = 1'b0;
  logic [7:0] data = '0;
  logic [0:7] bl0, bl1, wl0, prev_bl0, prev_bl1;
  logic [0:3] wl1;
  logic [2:0] row0;
  logic [1:0] row1;
  logic busy0, busy1, done0, done1;
  int n_vec = 0, n_err = 0, cyc = 0;
  int m_pos[2], m_row[2];
  logic m_busy[2], m_done[2];
  logic [0:7] m_bl[2];
  int hi0[8], hi1[4];
  always #5 clk = ~clk;
  bl_wl_config_writer_if #(.NUM_BL(8)) c0 ();
  bl_wl_config_writer_if #(.NUM_BL(8)) c1 ();
  assign c0.valid = valid;
  assign c0.data = data;
  assign c1.valid = valid;
  assign c1.data = data;
  bl_wl_config_writer u0 (
    .prog_clk(clk), .pReset(rst), .cfg_start(start), .cfg(c0),
    .bl(bl0), .wl(wl0), .cfg_row(row0), .cfg_busy(busy0), .cfg_done(done0)
  );
  bl_wl_config_writer #(
    .NUM_BL(8), .NUM_WL(4), .BL_SETUP_CYC(2), .WL_PULSE_CYC(3), .BL_HOLD_CYC(1)
  ) u1 (
    .prog_clk(clk), .pReset(rst), .cfg_start(start), .cfg(c1),
    .bl(bl1), .wl(wl1), .cfg_row(row1), .cfg_busy(busy1), .cfg_done(done1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] exp_wl(input int k);
    return (m_busy[k] && m_pos[k] > S[k] && m_pos[k] <= S[k] + P[k]) ? 8'(8'h80 >> m_row[k]) : 8'h00;
  endfunction
  task automatic model(input int k);
    if (rst) begin
      m_busy[k] = 0; m_done[k] = 0; m_row[k] = 0; m_pos[k] = 0; m_bl[k] = '0;
    end else if (!m_busy[k]) begin
      if (start) begin
        m_busy[k] = 1; m_done[k] = 0; m_row[k] = 0; m_pos[k] = 0;
      end
    end else if (m_pos[k] == 0) begin
      if (valid) begin
        m_pos[k] = 1;
        for (int i = 0; i < 8; i++) m_bl[k][i] = data[i];
      end
    end else if (m_pos[k] < S[k] + P[k] + H[k]) m_pos[k]++;
    else if (m_row[k] == NW[k] - 1) begin
      m_busy[k] = 0; m_done[k] = 1; m_bl[k] = '0;
    end else begin
      m_row[k]++; m_pos[k] = 0;
    end
  endtask
  task automatic step();
    prev_bl0 = bl0;
    prev_bl1 = bl1;
    @(posedge clk);
    model(0);
    model(1);
    cyc++;
    #1;
    check("wl0", {24'b0, wl0}, {24'b0, exp_wl(0)});
    check("wl1", {24'b0, wl1, 4'b0}, {24'b0, exp_wl(1)});
    check("bl0", {24'b0, bl0}, {24'b0, m_bl[0]});
    check("bl1", {24'b0, bl1}, {24'b0, m_bl[1]});
    check("row0", {29'b0, row0}, m_row[0]);
    check("row1", {30'b0, row1}, m_row[1]);
    check("ready0", {31'b0, c0.ready}, {31'b0, m_busy[0] && m_pos[0] == 0});
    check("ready1", {31'b0, c1.ready}, {31'b0, m_busy[1] && m_pos[1] == 0});
    check("busy0", {31'b0, busy0}, {31'b0, m_busy[0]});
    check("busy1", {31'b0, busy1}, {31'b0, m_busy[1]});
    check("done0", {31'b0, done0}, {31'b0, m_done[0]});
    check("done1", {31'b0, done1}, {31'b0, m_done[1]});
    check("onehot0_wl0", {31'b0, $onehot0(wl0)}, 32'd1);
    check("onehot0_wl1", {31'b0, $onehot0(wl1)}, 32'd1);
    if (|wl0) check("bl_stable0", {24'b0, bl0}, {24'b0, prev_bl0});
    if (|wl1) check("bl_stable1", {24'b0, bl1}, {24'b0, prev_bl1});
    for (int r = 0; r < 8; r++) hi0[r] += int'(wl0[r]);
    for (int r = 0; r < 4; r++) hi1[r] += int'(wl1[r]);
  endtask
  initial begin
    int t0, lat1, stall;
    bit sent, reached;
    for (int k = 0; k < 2; k++) begin
      m_pos[k] = 0; m_row[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_bl[k] = '0;
    end
    prev_bl0 = '0;
    prev_bl1 = '0;
    step();
    step();
    rst = 1'b0;
    step();
    // full pass, valid held, row r carries 1<<r; a stray start at row 2 must be ignored
    for (int r = 0; r < 8; r++) hi0[r] = 0;
    for (int r = 0; r < 4; r++) hi1[r] = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc;
    lat1 = -1;
    sent = 0;
    valid = 1'b1;
    while (!(done0 && done1) && cyc - t0 < 200) begin
      data = 8'(1 << m_row[0]);
      start = !sent && m_row[0] == 2 && m_pos[0] == 2;
      if (start) sent = 1;
      step();
      start = 1'b0;
      if (done0 && t0 >= 0) begin
        check("done_latency0", cyc - t0, 40);
        t0 = -100000;
      end
      if (done1 && lat1 < 0) lat1 = cyc - t0;
    end
    check("pass_a_done0", {31'b0, done0}, 32'd1);
    check("done_latency1", lat1, 28);
    for (int r = 0; r < 8; r++) check("pulse_len0", hi0[r], 2);
    for (int r = 0; r < 4; r++) check("pulse_len1", hi1[r], 3);
    // restart from done, stall 3 cycles in row 3 fetch, then reset in row 5 pulse
    start = 1'b1;
    step();
    start = 1'b0;
    stall = 0;
    reached = 0;
    for (int n = 0; n < 300 && !reached; n++) begin
      valid = !(m_row[0] == 3 && m_pos[0] == 0 && stall < 3);
      if (!valid) stall++;
      data = 8'($urandom);
      step();
      reached = m_row[0] == 5 && m_pos[0] == 2;
    end
    check("reach_row5_pulse", {31'b0, reached}, 32'd1);
    check("stall_cycles", stall, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    // fresh pass after the mid-pulse reset
    start = 1'b1;
    step();
    start = 1'b0;
    valid = 1'b1;
    for (int n = 0; n < 300 && !(done0 && done1); n++) begin
      data = 8'($urandom);
      step();
    end
    check("pass_c_done", {30'b0, done0, done1}, 32'd3);
    // random traffic with sporadic start, backpressure and reset
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 19) == 0;
      valid = $urandom_range(0, 3) != 0;
      data = 8'($urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
